// File: rtl/boot_packet_loader.sv
// Boot packet loader: parses MAGIC/LEN/BASE/payload/CHK frames and writes
// little-endian words to instruction memory. Optional macro: BOOT_PACKET_TIMEOUT_EN.
module boot_packet_loader #(
  parameter int         WORD_BYTES     = 4,
  parameter int         ADDR_WIDTH     = 10,
  parameter int         IMEM_DEPTH     = 1024,
  parameter logic [7:0] MAGIC          = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                byte_data,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  input  logic                      boot_start,
  output logic [8*WORD_BYTES-1:0]   mem_wr_data,
  output logic [ADDR_WIDTH-1:0]     mem_wr_addr,
  output logic                      mem_wr_en,
  output logic                      busy,
  output logic                      boot_done,
  output logic                      boot_error,
  output logic [1:0]                error_code,
  output logic [ADDR_WIDTH:0]       words_written
);

  typedef enum logic [2:0] {SYNC, HDR, DATA, CHK, DONE, ERROR} state_t;

  localparam logic [2:0]  LAST_IDX = 3'(WORD_BYTES - 1);
  localparam logic [17:0] DEPTH_W  = 18'(IMEM_DEPTH);

  state_t                  state;
  logic [7:0]              sum;
  logic [1:0]              hdr_cnt;
  logic [15:0]             len;
  logic [7:0]              base_lo;
  logic [15:0]             words_left;
  logic [2:0]              byte_idx;
  logic [8*WORD_BYTES-1:0] word_reg;
  logic [8*WORD_BYTES-1:0] next_word;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    accept;
  logic [7:0]              sum_next;
  logic [16:0]             base_end;
  logic [15:0]             base_full;

  assign accept    = byte_valid && byte_ready;
  assign sum_next  = sum + byte_data;
  assign base_full = {byte_data, base_lo};
  assign base_end  = {1'b0, base_full} + {1'b0, len};

  // Current word with the incoming byte dropped into its little-endian lane.
  always_comb begin
    next_word = word_reg;
    for (int i = 0; i < WORD_BYTES; i++)
      if (byte_idx == 3'(i)) next_word[i*8 +: 8] = byte_data;
  end

`ifdef BOOT_PACKET_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] idle_cnt;
`endif

  // NOTE: every register here uses <=, so all reads see the pre-edge value and
  // busy/byte_ready are updated alongside each state transition they track.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= SYNC;
      byte_ready    <= 1'b1;
      busy          <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_wr_data   <= '0;
      mem_wr_addr   <= '0;
      boot_done     <= 1'b0;
      boot_error    <= 1'b0;
      error_code    <= 2'd0;
      words_written <= '0;
      sum           <= 8'd0;
      hdr_cnt       <= 2'd0;
      len           <= 16'd0;
      base_lo       <= 8'd0;
      words_left    <= 16'd0;
      byte_idx      <= 3'd0;
      word_reg      <= '0;
      wr_addr       <= '0;
`ifdef BOOT_PACKET_TIMEOUT_EN
      idle_cnt      <= 32'd0;
`endif
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        SYNC: if (accept && byte_data == MAGIC) begin
          state         <= HDR;
          busy          <= 1'b1;
          sum           <= 8'd0;
          hdr_cnt       <= 2'd0;
          byte_idx      <= 3'd0;
          word_reg      <= '0;
          words_written <= '0;
        end
        HDR: if (accept) begin
          sum     <= sum_next;
          hdr_cnt <= hdr_cnt + 2'd1;
          case (hdr_cnt)
            2'd0: len[7:0]  <= byte_data;
            2'd1: len[15:8] <= byte_data;
            2'd2: base_lo   <= byte_data;
            2'd3: begin
              // Range check is done wide so BASE + N cannot wrap.
              if (len == 16'd0 || {1'b0, base_end} > DEPTH_W) begin
                state      <= ERROR;
                busy       <= 1'b0;
                byte_ready <= 1'b0;
                boot_error <= 1'b1;
                error_code <= 2'd1;
              end else begin
                state      <= DATA;
                wr_addr    <= ADDR_WIDTH'(base_full);
                words_left <= len;
              end
            end
          endcase
        end
        DATA: if (accept) begin
          sum <= sum_next;
          if (byte_idx == LAST_IDX) begin
            mem_wr_en     <= 1'b1;
            mem_wr_data   <= next_word;
            mem_wr_addr   <= wr_addr;
            wr_addr       <= wr_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            words_written <= words_written + {{ADDR_WIDTH{1'b0}}, 1'b1};
            words_left    <= words_left - 16'd1;
            byte_idx      <= 3'd0;
            word_reg      <= '0;
            if (words_left == 16'd1) state <= CHK;
          end else begin
            word_reg <= next_word;
            byte_idx <= byte_idx + 3'd1;
          end
        end
        CHK: if (accept) begin
          sum        <= sum_next;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
          if (sum_next == 8'd0) begin
            state     <= DONE;
            boot_done <= 1'b1;
          end else begin
            state      <= ERROR;
            boot_error <= 1'b1;
            error_code <= 2'd2;
          end
        end
        DONE, ERROR: if (boot_start) begin
          state      <= SYNC;
          byte_ready <= 1'b1;
          boot_done  <= 1'b0;
          boot_error <= 1'b0;
          error_code <= 2'd0;
        end
        default: begin
          state      <= SYNC;
          byte_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
`ifdef BOOT_PACKET_TIMEOUT_EN
      // Idle watchdog only runs while a packet is in flight.
      if (state == HDR || state == DATA || state == CHK) begin
        if (accept) begin
          idle_cnt <= 32'd0;
        end else if (idle_cnt == TO_LAST - 32'd1) begin
          idle_cnt   <= 32'd0;
          state      <= ERROR;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
          boot_error <= 1'b1;
          error_code <= 2'd3;
          byte_idx   <= 3'd0;
          word_reg   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end else begin
        idle_cnt <= 32'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_boot_packet_loader.sv
// Directed self-checking bench for boot_packet_loader (WORD_BYTES=4, IMEM_DEPTH=1024).
module tb_boot_packet_loader;

  localparam int WB = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          boot_start = 1'b0;
  logic [8*WB-1:0] mem_wr_data;
  logic [AW-1:0] mem_wr_addr;
  logic          mem_wr_en;
  logic          busy;
  logic          boot_done;
  logic          boot_error;
  logic [1:0]    error_code;
  logic [AW:0]   words_written;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0]   s_addr[$];
  logic [8*WB-1:0] s_data[$];
  logic [7:0]      pkt[$];

  boot_packet_loader #(
    .WORD_BYTES(WB), .ADDR_WIDTH(AW), .IMEM_DEPTH(1024),
    .MAGIC(8'hA5), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .boot_start(boot_start), .mem_wr_data(mem_wr_data),
    .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en), .busy(busy),
    .boot_done(boot_done), .boot_error(boot_error), .error_code(error_code),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Strobe log, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      s_addr.push_back(mem_wr_addr);
      s_data.push_back(mem_wr_data);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (byte_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte_accept: byte %h not accepted in 50 cycles", b);
    end
  endtask

  task automatic send_pkt(input bit rnd);
    foreach (pkt[i]) send_byte(pkt[i], rnd ? int'($urandom_range(0, 2)) : 0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_flags(input string name);
    int n;
    for (n = 0; n < 50; n++) begin
      if (boot_done === 1'b1 || boot_error === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (n == 50) begin
      errors++;
      $display("FAIL %s_wait: no done/error within 50 cycles", name);
    end
  endtask

  task automatic check_done(input string name, input int ww);
    checks++;
    if (boot_done !== 1'b1 || boot_error !== 1'b0 || error_code !== 2'd0) begin
      errors++;
      $display("FAIL %s_done: done=%b err=%b code=%0d, want 1 0 0", name, boot_done, boot_error, error_code);
    end
    checks++;
    if (words_written !== (AW+1)'(ww)) begin
      errors++;
      $display("FAIL %s_words: got %0d want %0d", name, words_written, ww);
    end
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b ready=%b, want 0 0", name, busy, byte_ready);
    end
  endtask

  task automatic check_strobe(input string name, input int idx, input logic [AW-1:0] a, input logic [8*WB-1:0] d);
    checks++;
    if (idx >= s_addr.size()) begin
      errors++;
      $display("FAIL %s_strobe%0d: missing, only %0d strobes", name, idx, s_addr.size());
    end else if (s_addr[idx] !== a || s_data[idx] !== d) begin
      errors++;
      $display("FAIL %s_strobe%0d: got %h/%h want %h/%h", name, idx, s_addr[idx], s_data[idx], a, d);
    end
  endtask

  task automatic check_count(input string name, input int n);
    checks++;
    if (s_addr.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d strobes want %0d", name, s_addr.size(), n);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (byte_ready !== 1'b1 || mem_wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctl: ready=%b wr_en=%b busy=%b want 1 0 0", name, byte_ready, mem_wr_en, busy);
    end
    checks++;
    if (mem_wr_data !== '0 || mem_wr_addr !== '0 || words_written !== '0) begin
      errors++;
      $display("FAIL %s_mem: data=%h addr=%h ww=%0d want 0", name, mem_wr_data, mem_wr_addr, words_written);
    end
    checks++;
    if (boot_done !== 1'b0 || boot_error !== 1'b0 || error_code !== 2'd0) begin
      errors++;
      $display("FAIL %s_flags: done=%b err=%b code=%0d want 0", name, boot_done, boot_error, error_code);
    end
  endtask

  task automatic rearm(input string name);
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    checks++;
    if (byte_ready !== 1'b1 || boot_done !== 1'b0 || boot_error !== 1'b0 || error_code !== 2'd0) begin
      errors++;
      $display("FAIL %s_rearm: ready=%b done=%b err=%b code=%0d", name, byte_ready, boot_done, boot_error, error_code);
    end
    s_addr.delete();
    s_data.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");
  endtask

  task automatic test_basic;
    s_addr.delete();
    s_data.delete();
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'hCA};
    send_pkt(1'b0);
    wait_flags("basic");
    check_count("basic", 2);
    check_strobe("basic", 0, 10'h010, 32'h04030201);
    check_strobe("basic", 1, 10'h011, 32'h08070605);
    check_done("basic", 2);
  endtask

  task automatic test_garbage;
    rearm("garbage");
    pkt = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h00, 8'h20, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h35};
    send_pkt(1'b1);
    wait_flags("garbage");
    check_count("garbage", 1);
    check_strobe("garbage", 0, 10'h020, 32'h44332211);
    check_done("garbage", 1);
  endtask

  task automatic test_range;
    rearm("range");
    pkt = '{8'hA5, 8'h04, 8'h00, 8'hFE, 8'h03};
    send_pkt(1'b0);
    wait_flags("range");
    checks++;
    if (boot_error !== 1'b1 || error_code !== 2'd1 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL range_err: err=%b code=%0d done=%b want 1 1 0", boot_error, error_code, boot_done);
    end
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL range_ready: ready=%b busy=%b want 0 0", byte_ready, busy);
    end
    check_count("range", 0);
    // Zero-length packet is also a length error.
    rearm("zero_len");
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(1'b0);
    wait_flags("zero_len");
    checks++;
    if (boot_error !== 1'b1 || error_code !== 2'd1) begin
      errors++;
      $display("FAIL zero_len_err: err=%b code=%0d want 1 1", boot_error, error_code);
    end
    check_count("zero_len", 0);
  endtask

  task automatic test_top_word;
    rearm("top_word");
    pkt = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC5};
    send_pkt(1'b0);
    wait_flags("top_word");
    check_count("top_word", 1);
    check_strobe("top_word", 0, 10'h3FF, 32'hEFBEADDE);
    check_done("top_word", 1);
  endtask

  task automatic test_checksum;
    rearm("chk_bad");
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'hCB};
    send_pkt(1'b0);
    wait_flags("chk_bad");
    check_count("chk_bad", 2);
    checks++;
    if (boot_error !== 1'b1 || error_code !== 2'd2 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL chk_bad_err: err=%b code=%0d done=%b want 1 2 0", boot_error, error_code, boot_done);
    end
    checks++;
    if (words_written !== (AW+1)'(2)) begin
      errors++;
      $display("FAIL chk_bad_words: got %0d want 2", words_written);
    end
    rearm("chk_retry");
    pkt[13] = 8'hCA;
    send_pkt(1'b0);
    wait_flags("chk_retry");
    check_count("chk_retry", 2);
    check_strobe("chk_retry", 1, 10'h011, 32'h08070605);
    check_done("chk_retry", 2);
  endtask

  task automatic test_reset_mid;
    rearm("rst_mid");
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(1'b0);
    checks++;
    if (busy !== 1'b1 || mem_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy: busy=%b wr_en=%b want 1 1", busy, mem_wr_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("rst_mid");
    check_count("rst_mid_first", 1);
    pkt = '{8'h05, 8'h06, 8'h07, 8'h08, 8'hCA};
    send_pkt(1'b0);
    check_count("rst_mid_tail", 1);
    check_reset_vals("rst_mid_sync");
    s_addr.delete();
    s_data.delete();
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'hCA};
    send_pkt(1'b0);
    wait_flags("rst_mid_reload");
    check_count("rst_mid_reload", 2);
    check_strobe("rst_mid_reload", 0, 10'h010, 32'h04030201);
    check_done("rst_mid_reload", 2);
  endtask

`ifdef BOOT_PACKET_TIMEOUT_EN
  task automatic test_timeout;
    int k;
    rearm("timeout");
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send_pkt(1'b0);
    for (k = 0; k < 200; k++) begin
      if (boot_error === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (k != 49) begin
      errors++;
      $display("FAIL timeout_cycles: error after %0d idle cycles want 49", k);
    end
    checks++;
    if (error_code !== 2'd3) begin
      errors++;
      $display("FAIL timeout_code: got %0d want 3", error_code);
    end
    check_count("timeout", 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_range();
    test_top_word();
    test_checksum();
    test_reset_mid();
`ifdef BOOT_PACKET_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_packet_loader.md
Name: boot_packet_loader

Overview:
Second-generation instruction-memory loader. It consumes a byte stream that has already been synchronised into the CPU clock domain, for example from the async FIFO read side. The stream carries a framed boot packet: magic byte, word count, base address, payload and checksum. The block assembles little-endian words of parametrised width, writes them to instruction memory at a host-chosen base address, and validates length, range and checksum. It reports done/error with an error code, and can be re-armed without reset.

Parameters:
- WORD_BYTES, 4: bytes per memory word; mem_wr_data width = 8*WORD_BYTES; legal values 1..8.
- ADDR_WIDTH, 10: memory word-address width.
- IMEM_DEPTH, 1024: number of writable words; IMEM_DEPTH <= 2**ADDR_WIDTH.
- MAGIC, 8'hA5: packet start byte.
- TIMEOUT_CYCLES, 1_000_000: idle cycles between bytes before abort; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous reset, active-low.
- byte_data  in  8  incoming byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte; a byte transfers when byte_valid && byte_ready at the clk edge.
- boot_start  in  1  one-cycle re-arm pulse; honoured only in DONE or ERROR.
- mem_wr_data  out  8*WORD_BYTES  assembled word.
- mem_wr_addr  out  ADDR_WIDTH  word address.
- mem_wr_en  out  1  one-cycle write strobe.
- busy  out  1  high while in HDR, DATA or CHK.
- boot_done  out  1  packet loaded and checksum good; sticky.
- boot_error  out  1  packet rejected; sticky.
- error_code  out  2  0 = none, 1 = length/range, 2 = checksum, 3 = timeout.
- words_written  out  ADDR_WIDTH+1  words written in the current packet.

Behaviour:
- Reset (rst_n = 0 at a clk edge): state SYNC.
  - Outputs: byte_ready = 1, mem_wr_en = 0, mem_wr_data = 0, mem_wr_addr = 0, busy = 0, boot_done = 0, boot_error = 0, error_code = 0, words_written = 0.
  - Internal state: sum, byte and word counters all 0.
- Packet format, in order: MAGIC, LEN_LO, LEN_HI, BASE_LO, BASE_HI, then N*WORD_BYTES payload bytes, then CHK.
  - N = {LEN_HI, LEN_LO} words; BASE = {BASE_HI, BASE_LO} word address.
  - Each word is little-endian: the first byte goes to bits [7:0].
- Checksum: 8-bit modulo-256 sum of every byte from LEN_LO through CHK inclusive must equal 8'h00. MAGIC is excluded.
- SYNC: byte_ready = 1. Non-MAGIC bytes are discarded. MAGIC moves to HDR and clears sum, counters and words_written.
- HDR: accepts 4 bytes.
  - On the 4th byte the length/range check runs. N == 0, or BASE + N > IMEM_DEPTH (17-bit compare, no wrap), goes to ERROR with code 1 and no memory writes.
  - Otherwise go to DATA with the write address = BASE.
- DATA: byte_ready = 1 and bytes shift into a word register.
  - The cycle after accepting the last byte of a word: mem_wr_en = 1 for exactly one cycle, with mem_wr_data set to the word and mem_wr_addr set to the current address. Address and words_written then increment.
  - Back-to-back bytes are legal: one byte per cycle, zero bubbles. For WORD_BYTES = 1 that means consecutive write strobes.
  - After word N is written, go to CHK.
- CHK: accepts one byte, added to the sum.
  - Sum == 0: DONE, boot_done = 1.
  - Sum != 0: ERROR, code 2.
  - Words already written are left in memory; boot_error flags the image as invalid.
- DONE / ERROR:
  - byte_ready = 0, busy = 0; flags and error_code hold.
  - A boot_start pulse clears boot_done, boot_error and error_code, and returns to SYNC on the next cycle.
  - boot_start is ignored in all other states.
- busy = 1 exactly in HDR, DATA and CHK.
- The write for word N and the CHK byte may not coincide: CHK is accepted no earlier than the cycle of the last write strobe. This is legal since the strobe is registered.
- All flag and strobe outputs are registered; there are no combinational paths from inputs to mem_wr_* or flags. byte_ready is a function of state only.
- Reset mid-packet aborts immediately: no further strobes, all outputs return to their reset values.

Optional Feature:
- Macro: BOOT_PACKET_TIMEOUT_EN.
- Defined:
  - In HDR, DATA and CHK, an idle counter clears on every accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1, the block goes to ERROR with code 3 and any partial word is dropped.
  - The counter is held at 0 in SYNC, DONE and ERROR.
- Undefined: no counter logic; the loader waits indefinitely; code 3 is never produced.

Test Plan:
- Packet A5, 02 00, 10 00, bytes 01..08, then the correct CHK, sent back-to-back, WORD_BYTES = 4 -> strobes at addr 0x010 data 0x04030201 and addr 0x011 data 0x08070605; boot_done = 1, error_code = 0, words_written = 2.
- Garbage bytes 00 FF 13 before A5, then a valid 1-word packet with byte_valid toggling randomly -> garbage ignored; one strobe with correct data; boot_done = 1.
- Header N = 0x0004, BASE = 0x03FE (IMEM_DEPTH = 1024) -> ERROR with code 1 on the 4th header byte; zero strobes; byte_ready = 0.
- Valid 2-word packet with CHK off by +1 -> 2 strobes, then boot_error = 1, error_code = 2; after a boot_start pulse, flags clear and a correct packet loads with boot_done = 1.
- rst_n low for 1 cycle after the first payload word -> no further strobes, all outputs at reset values, state SYNC; a subsequent full packet loads correctly.
- With BOOT_PACKET_TIMEOUT_EN and TIMEOUT_CYCLES = 50: stop after 2 payload bytes -> error_code = 3 exactly 49 idle cycles after the last accept; no strobe for the partial word.
